// File: rtl/data_mem_subsystem.sv
// ---------------------------------------------------------------------------
// control_types_pkg / data_mem_subsystem
//
// Data-side memory subsystem driven by the CPU MEM stage.
//   * Word-organised data RAM with byte/half/word loads (sign or zero
//     extended) and byte-lane stores. Reads are combinational; writes
//     commit on the rising edge.
//   * MMIO window at 0x8000_0000..0x8000_000F:
//       +0x0 TX       write pushes a byte into the console TX FIFO
//       +0x4 STATUS   {count[7:4], OVF[2], empty[1], full[0]}, W1C on OVF
//       +0x8 CYCLE_LO low half of the cycle counter (latches high half)
//       +0xC CYCLE_HI high half captured by the last CYCLE_LO read
//   * Sticky bus_err for misaligned, unmapped or non-word MMIO accesses.
//
// Ports
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   mem_wr_en    in   store strobe
//   mem_op       in   access type (mem_op_t)
//   mem_addr     in   byte address
//   mem_data_in  in   store data (low byte/half used for narrow stores)
//   mem_data_out out  load data, 0 when nothing is loaded
//   tx_valid     out  FIFO head valid
//   tx_data      out  FIFO head byte
//   tx_ready     in   sink accepts head
//   bus_err      out  sticky access error flag
// ---------------------------------------------------------------------------
package control_types_pkg;
  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_B    = 3'd1,
    MEM_H    = 3'd2,
    MEM_W    = 3'd3,
    MEM_BU   = 3'd4,
    MEM_HU   = 3'd5
  } mem_op_t;
endpackage

module data_mem_subsystem
  import control_types_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_wr_en,
  input  mem_op_t     mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = FW + 1;  // extra bit separates full from empty
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0] ram_q [DEPTH_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          bus_err_q, bus_err_d;
  logic [63:0]   cycle_q, cycle_d;
  logic [31:0]   hi_snap_q, hi_snap_d;

  // ---------------- decode ----------------
  logic          access, is_byte, is_half, is_word, misaligned;
  logic          in_ram, in_mmio, bad, ok;
  logic          ram_we, mmio_wr, mmio_rd;
  logic [1:0]    reg_sel;
  logic [AW-1:0] word_idx;

  always_comb begin
    access     = (mem_op != MEM_NONE);
    is_byte    = (mem_op == MEM_B) || (mem_op == MEM_BU);
    is_half    = (mem_op == MEM_H) || (mem_op == MEM_HU);
    is_word    = (mem_op == MEM_W);
    misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
    in_ram     = (mem_addr < RAM_BYTES);
    in_mmio    = (mem_addr[31:4] == 28'h8000000);
    bad        = access && (misaligned || !(in_ram || in_mmio) || (in_mmio && !is_word));
    ok         = access && !bad;
    ram_we     = ok && in_ram && mem_wr_en;
    mmio_wr    = ok && in_mmio && mem_wr_en;
    mmio_rd    = ok && in_mmio && !mem_wr_en;
    reg_sel    = mem_addr[3:2];
    word_idx   = mem_addr[AW+1:2];
  end

  // ---------------- RAM ----------------
  logic [3:0]  lane_mask;
  logic [31:0] wdata, rd_word, rd_shift, ram_rdata;

  always_comb begin
    lane_mask = 4'b0000;
    wdata     = mem_data_in;
    if (is_byte) begin
      lane_mask[mem_addr[1:0]] = 1'b1;
      wdata = {4{mem_data_in[7:0]}};
    end else if (is_half) begin
      lane_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{mem_data_in[15:0]}};
    end else if (is_word) begin
      lane_mask = 4'b1111;
    end
  end

  // A store during reset must not land, hence the resetn qualifier.
  always_ff @(posedge clk) begin
    if (resetn && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) ram_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = ram_q[word_idx];
    rd_shift = rd_word >> {mem_addr[1:0], 3'b000};
    case (mem_op)
      MEM_B:   ram_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
      MEM_BU:  ram_rdata = {24'd0, rd_shift[7:0]};
      MEM_H:   ram_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
      MEM_HU:  ram_rdata = {16'd0, rd_shift[15:0]};
      MEM_W:   ram_rdata = rd_word;
      default: ram_rdata = 32'd0;
    endcase
  end

  // ---------------- TX FIFO / MMIO ----------------
  logic [PW-1:0] count;
  logic          fifo_empty, fifo_full, push_req, push, pop, overflow;
  logic [31:0]   status_word, mmio_rdata;

  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (count == PW'(FIFO_DEPTH));
    pop        = !fifo_empty && tx_ready;
    push_req   = mmio_wr && (reg_sel == 2'd0);
    // A pop on the same edge frees the slot the push needs.
    overflow   = push_req && fifo_full && !pop;
    push       = push_req && !overflow;

    status_word      = 32'd0;
    status_word[7:4] = 4'(count);
    status_word[2]   = ovf_q;
    status_word[1]   = fifo_empty;
    status_word[0]   = fifo_full;

    case (reg_sel)
      2'd1:    mmio_rdata = status_word;
      2'd2:    mmio_rdata = cycle_q[31:0];
      2'd3:    mmio_rdata = hi_snap_q;
      default: mmio_rdata = 32'd0;
    endcase

    wr_ptr_d  = wr_ptr_q + {{(PW-1){1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    ovf_d     = ovf_q;
    if (mmio_wr && (reg_sel == 2'd1) && mem_data_in[2]) ovf_d = 1'b0;
    if (overflow) ovf_d = 1'b1;
    hi_snap_d = hi_snap_q;
    if (mmio_rd && (reg_sel == 2'd2)) hi_snap_d = cycle_q[63:32];
    bus_err_d = bus_err_q | bad;
    cycle_d   = cycle_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (resetn && push) fifo_q[wr_ptr_q[FW-1:0]] <= mem_data_in[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
      cycle_q   <= 64'd0;
      hi_snap_q <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
      cycle_q   <= cycle_d;
      hi_snap_q <= hi_snap_d;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    tx_valid = !fifo_empty;
    tx_data  = fifo_q[rd_ptr_q[FW-1:0]];
    bus_err  = bus_err_q;
    if (!ok || mem_wr_en) mem_data_out = 32'd0;
    else if (in_ram)      mem_data_out = ram_rdata;
    else                  mem_data_out = mmio_rdata;
  end

endmodule

// File: tb/tb_data_mem_subsystem.sv
// Testbench for data_mem_subsystem: directed scenarios plus randomized
// traffic checked against a byte-level memory / queue reference model.
module tb_data_mem_subsystem;
  import control_types_pkg::*;

  localparam logic [31:0] TX_A  = 32'h8000_0000;
  localparam logic [31:0] ST_A  = 32'h8000_0004;
  localparam logic [31:0] CLO_A = 32'h8000_0008;
  localparam logic [31:0] CHI_A = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_wr_en = 1'b0;
  mem_op_t     mem_op = MEM_NONE;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_data_in = 32'd0;
  logic [31:0] mem_data_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        bus_err;

  data_mem_subsystem dut (
    .clk(clk), .resetn(resetn), .mem_wr_en(mem_wr_en), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_ram [4096];
  logic [7:0]  m_q[$];
  bit          m_ovf, m_err;
  logic [63:0] m_cycle;
  logic [31:0] m_hisnap;
  logic [7:0]  sink[$];

  logic [31:0] last_dout;
  logic        last_txv, last_err;
  logic [7:0]  last_txd;

  function automatic int size_of(input mem_op_t op);
    case (op)
      MEM_B, MEM_BU: return 1;
      MEM_H, MEM_HU: return 2;
      MEM_W:         return 4;
      default:       return 0;
    endcase
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'd4096;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a <= 32'h8000_000F);
  endfunction

  function automatic bit is_err(input mem_op_t op, input logic [31:0] a);
    int sz;
    sz = size_of(op);
    if (sz == 0) return 0;
    if (!is_ram(a) && !is_mmio(a)) return 1;
    if ((a % sz) != 0) return 1;
    if (is_mmio(a) && sz != 4) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_load(input mem_op_t op, input logic [31:0] a);
    longint v;
    int sz;
    sz = size_of(op);
    if (sz == 0 || is_err(op, a)) return 32'd0;
    if (is_ram(a)) begin
      v = 0;
      for (int k = 0; k < sz; k++) v = v + (longint'(m_ram[int'(a) + k]) << (8 * k));
      if ((op == MEM_B || op == MEM_H) && v >= (longint'(1) << (8 * sz - 1)))
        v = v - (longint'(1) << (8 * sz));
      return v[31:0];
    end
    case ((a - 32'h8000_0000) / 4)
      1:       return 32'(m_q.size() * 16 + int'(m_ovf) * 4
                          + (m_q.size() == 0 ? 2 : 0) + (m_q.size() == 8 ? 1 : 0));
      2:       return m_cycle[31:0];
      3:       return m_hisnap;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_err = 0; m_cycle = 64'd0; m_hisnap = 32'd0;
  endtask

  task automatic model_edge(input mem_op_t op, input bit wr, input logic [31:0] a,
                            input logic [31:0] d);
    bit pop, full, do_push, err;
    int sz;
    sz      = size_of(op);
    err     = is_err(op, a);
    pop     = (m_q.size() > 0) && tx_ready;
    full    = (m_q.size() == 8);
    do_push = 0;
    if (sz != 0 && !err) begin
      if (is_ram(a)) begin
        if (wr) for (int k = 0; k < sz; k++) m_ram[int'(a) + k] = 8'(d >> (8 * k));
      end else if (wr) begin
        if (a == TX_A) begin
          if (full && !pop) m_ovf = 1; else do_push = 1;
        end else if (a == ST_A && d[2]) m_ovf = 0;
      end else if (a == CLO_A) begin
        m_hisnap = m_cycle[63:32];
      end
    end
    if (pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(d[7:0]);
    if (err) m_err = 1;
    m_cycle = m_cycle + 64'd1;
  endtask

  // One bus transaction: drive at negedge, check combinational outputs,
  // let the edge commit, update the model.
  task automatic step(input mem_op_t op, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
    mem_op = op; mem_wr_en = wr; mem_addr = a; mem_data_in = d;
    #1;
    last_dout = mem_data_out; last_txv = tx_valid; last_txd = tx_data; last_err = bus_err;
    if (!(wr && op != MEM_NONE)) check_eq({tag, ".dout"}, mem_data_out, exp_load(op, a));
    check_eq({tag, ".txv"}, tx_valid, m_q.size() > 0);
    if (m_q.size() > 0) check_eq({tag, ".txd"}, tx_data, m_q[0]);
    check_eq({tag, ".err"}, bus_err, m_err);
    if (tx_valid && tx_ready) sink.push_back(tx_data);
    $display("[%0t] %s op=%s we=%0b addr=%08h din=%08h dout=%08h txv=%0b txd=%02h err=%0b",
             $time, tag, op.name(), wr, a, d, mem_data_out, tx_valid, tx_data, bus_err);
    @(posedge clk);
    model_edge(op, wr, a, d);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_op_t     rop;
    logic [31:0] ra;
    int          r;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst.txv", tx_valid, 1'b0);
    check_eq("rst.err", bus_err, 1'b0);
    check_eq("rst.dout", mem_data_out, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // ---------------- cycle counter after 100 cycles ----------------
    repeat (100) step(MEM_NONE, 0, 32'd0, 32'd0, "idle");
    step(MEM_W, 0, CLO_A, 32'd0, "cyc100");
    check_eq("cyc100.const", last_dout, 32'd100);

    // ---------------- RAM init + directed ----------------
    for (int w = 0; w < 64; w++) step(MEM_W, 1, 32'(4 * w), $urandom, "init");
    step(MEM_W, 1, 32'h10, 32'h1234_5678, "sw10");
    step(MEM_W, 0, 32'h10, 32'd0, "lw10");   check_eq("lw10.const", last_dout, 32'h1234_5678);
    step(MEM_B, 0, 32'h13, 32'd0, "lb13");   check_eq("lb13.const", last_dout, 32'h0000_0012);
    step(MEM_H, 0, 32'h12, 32'd0, "lh12");   check_eq("lh12.const", last_dout, 32'h0000_1234);
    step(MEM_B, 0, 32'h10, 32'd0, "lb10");   check_eq("lb10.const", last_dout, 32'h0000_0078);
    step(MEM_B, 1, 32'h11, 32'h0000_00FF, "sb11");
    step(MEM_W, 0, 32'h10, 32'd0, "lw10b");  check_eq("lw10b.const", last_dout, 32'h1234_FF78);
    step(MEM_B, 0, 32'h11, 32'd0, "lb11");   check_eq("lb11.const", last_dout, 32'hFFFF_FFFF);
    step(MEM_BU, 0, 32'h11, 32'd0, "lbu11"); check_eq("lbu11.const", last_dout, 32'h0000_00FF);

    // ---------------- FIFO overflow and drain ----------------
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(MEM_W, 1, TX_A, 32'(8'h41 + i), "push");
    step(MEM_W, 0, ST_A, 32'd0, "st_full"); check_eq("st_full.const", last_dout, 32'h81);
    step(MEM_W, 1, TX_A, 32'h49, "push9");
    step(MEM_W, 0, ST_A, 32'd0, "st_ovf");  check_eq("st_ovf.const", last_dout, 32'h85);
    step(MEM_W, 1, ST_A, 32'h4, "clr_ovf");
    step(MEM_W, 0, ST_A, 32'd0, "st_clr");  check_eq("st_clr.const", last_dout, 32'h81);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(MEM_NONE, 0, 32'd0, 32'd0, "drain");
      check_eq("drain.valid", last_txv, 1'b1);
      check_eq("drain.byte", last_txd, 32'(8'h41 + i));
    end
    step(MEM_NONE, 0, 32'd0, 32'd0, "drained");
    check_eq("drained.valid", last_txv, 1'b0);

    // ---------------- full FIFO, push and pop together ----------------
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(MEM_W, 1, TX_A, 32'(8'h61 + i), "push2");
    tx_ready = 1'b1;
    sink.delete();
    step(MEM_W, 1, TX_A, 32'h5A, "push_pop");
    step(MEM_W, 0, ST_A, 32'd0, "st_pp");   check_eq("st_pp.const", last_dout, 32'h81);
    repeat (10) step(MEM_NONE, 0, 32'd0, 32'd0, "drain2");
    check_eq("drain2.count", sink.size(), 9);
    if (sink.size() > 0) check_eq("drain2.last", sink[sink.size() - 1], 8'h5A);

    // ---------------- error cases ----------------
    check_eq("err.before", last_err, 1'b0);
    step(MEM_W, 0, 32'h2, 32'd0, "lw_mis");  check_eq("lw_mis.const", last_dout, 32'd0);
    step(MEM_H, 0, 32'h3, 32'd0, "lh_mis");  check_eq("lh_mis.const", last_dout, 32'd0);
    check_eq("err.after", last_err, 1'b1);
    step(MEM_W, 0, 32'h0, 32'd0, "lw0");
    step(MEM_W, 1, 32'h4000_0000, 32'hCAFE_F00D, "sw_unmap");
    step(MEM_W, 0, 32'h0, 32'd0, "lw0b");
    check_eq("err.sticky", last_err, 1'b1);

    // ---------------- cycle counter carry into the high half ----------------
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cycle = 64'h0000_0000_FFFF_FFFF;
    step(MEM_W, 0, CLO_A, 32'd0, "clo_max"); check_eq("clo_max.const", last_dout, 32'hFFFF_FFFF);
    step(MEM_NONE, 0, 32'd0, 32'd0, "gap");
    step(MEM_W, 0, CHI_A, 32'd0, "chi");     check_eq("chi.const", last_dout, 32'd0);
    step(MEM_W, 0, CLO_A, 32'd0, "clo_wrap");
    step(MEM_W, 0, CHI_A, 32'd0, "chi2");    check_eq("chi2.const", last_dout, 32'd1);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 400; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      rop = mem_op_t'($urandom_range(0, 5));
      r = int'($urandom_range(0, 99));
      if (r < 80)      ra = 32'($urandom_range(0, 255));
      else if (r < 92) ra = 32'h8000_0000 + 32'($urandom_range(0, 15));
      else             ra = 32'h4000_0000 | 32'($urandom_range(0, 255));
      step(rop, 1'($urandom_range(0, 1)), ra, $urandom, "rnd");
    end

    // ---------------- reset mid-operation ----------------
    tx_ready = 1'b1;
    repeat (10) step(MEM_NONE, 0, 32'd0, 32'd0, "flush");
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(MEM_W, 1, TX_A, 32'(8'h31 + i), "push3");
    mem_op = MEM_W; mem_wr_en = 1'b1; mem_addr = 32'h20; mem_data_in = 32'hDEAD_BEEF;
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rstmid.txv", tx_valid, 1'b0);
    check_eq("rstmid.err", bus_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mem_op = MEM_NONE; mem_wr_en = 1'b0;
    resetn = 1'b1;
    model_reset();
    step(MEM_W, 0, ST_A, 32'd0, "st_rst");  check_eq("st_rst.const", last_dout, 32'h02);
    step(MEM_W, 0, 32'h20, 32'd0, "lw20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
